mult_pipe: RTL and testbench

MULT_PIPE -- requirements
Module: mult_pipe

---
 rtl/mult_pipe_pkg.sv | 21 ++
 rtl/mult_pipe_stage.sv | 37 +++
 rtl/mult_pipe.sv | 123 ++++++++++++
 tb/tb_mult_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the mult_pipe shift-and-add multiplier.
// Signed support is compiled in only when MULT_PIPE_SIGNED_EN is defined.
package mult_pipe_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    // Records are sized for the widest legal operand. Narrower builds keep the
    // upper bits at zero, and synthesis prunes that logic away.
    typedef struct packed {
        logic                     valid;
        logic                     sign;
        logic [MAX_WIDTH-1:0]     mcand;
        logic [MAX_WIDTH-1:0]     mplier;
        logic [2*MAX_WIDTH-1:0]   psum;
    } stage_t;

    function automatic int unsigned lat(int unsigned width, int unsigned bps);
        return width / bps + 2;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One accumulate stage: retires BITS_PER_STAGE multiplier bits into the partial sum.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int unsigned BITS_PER_STAGE = 1,
    parameter int unsigned STAGE          = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t rec_in,
    output stage_t rec_out
);

    localparam int unsigned PW    = 2 * MAX_WIDTH;
    localparam int unsigned SHIFT = STAGE * BITS_PER_STAGE;

    logic [BITS_PER_STAGE-1:0] digit;
    logic [PW-1:0]             term;
    stage_t                    rec_next;

    always_comb begin
        digit            = rec_in.mplier[SHIFT +: BITS_PER_STAGE];
        term             = (PW'(digit) * PW'(rec_in.mcand)) << SHIFT;
        rec_next         = rec_in;
        rec_next.psum    = rec_in.psum + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_out <= '0;
        end else if (en) begin
            rec_out <= rec_next;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined multiplier: input register, WIDTH/BITS_PER_STAGE accumulate stages, output register.
// Define MULT_PIPE_SIGNED_EN to compile in two's-complement support via is_signed.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] y
);

    localparam int unsigned NSTAGE = lat(WIDTH, BITS_PER_STAGE) - 2;

    if ((WIDTH % BITS_PER_STAGE) != 0 || WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("mult_pipe: WIDTH must be 2..64 and a multiple of BITS_PER_STAGE");
    end

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             res_sign;

`ifdef MULT_PIPE_SIGNED_EN
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        res_sign = a_neg ^ b_neg;
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;

    always_comb begin
        a_mag    = a;
        b_mag    = b;
        res_sign = 1'b0;
    end
`endif

    stage_t in_rec;
    stage_t in_q;

    always_comb begin
        in_rec        = '0;
        in_rec.valid  = in_valid;
        in_rec.sign   = res_sign;
        in_rec.mcand  = MAX_WIDTH'(a_mag);
        in_rec.mplier = MAX_WIDTH'(b_mag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
        end else if (en) begin
            in_q <= in_rec;
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        stage_t rec_in;
        stage_t rec_out;

        if (k == 0) begin : g_first
            assign rec_in = in_q;
        end else begin : g_chain
            assign rec_in = g_stage[k-1].rec_out;
        end

        mult_pipe_stage #(
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .STAGE          (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .rec_in  (rec_in),
            .rec_out (rec_out)
        );
    end

    stage_t             last;
    logic [2*WIDTH-1:0] psum_w;
    logic [2*WIDTH-1:0] y_next;
    logic               unused_tail;

    assign last        = g_stage[NSTAGE-1].rec_out;
    assign psum_w      = last.psum[2*WIDTH-1:0];
    assign unused_tail = ^{last.mcand, last.mplier, last.psum, last.sign};

`ifdef MULT_PIPE_SIGNED_EN
    assign y_next = last.sign ? -psum_w : psum_w;
`else
    assign y_next = psum_w;
`endif

    // y only moves on a completed product, so it stays deterministic across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (en) begin
            out_valid <= last.valid;
            if (last.valid) begin
                y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: BITS_PER_STAGE=1 and =4 instances driven in lockstep.
// Expected values come from hand-computed constants and a delay-line reference model.
module tb_mult_pipe;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, is_signed;
    logic [15:0] a, b;
    logic        ov1, ov4;
    logic [31:0] y1, y4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_pipe #(.WIDTH(16), .BITS_PER_STAGE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
        .is_signed(is_signed), .out_valid(ov1), .y(y1)
    );

    mult_pipe #(.WIDTH(16), .BITS_PER_STAGE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
        .is_signed(is_signed), .out_valid(ov4), .y(y4)
    );

    // Reference model: LAT-1 entry delay lines feeding an output register.
    logic        m1_v [0:16];
    logic [31:0] m1_y [0:16];
    logic        m4_v [0:4];
    logic [31:0] m4_y [0:4];
    logic        m1_ov, m4_ov;
    logic [31:0] m1_oy, m4_oy;

    function automatic logic [31:0] ref_mul(logic [15:0] p, logic [15:0] q, logic s);
        logic signed [31:0] sp, sq;
        sp = {{16{p[15]}}, p};
        sq = {{16{q[15]}}, q};
`ifdef MULT_PIPE_SIGNED_EN
        if (s) return sp * sq;
`endif
        return {16'h0, p} * {16'h0, q};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 17; i++) begin m1_v[i] = 1'b0; m1_y[i] = '0; end
            for (int i = 0; i < 5; i++) begin m4_v[i] = 1'b0; m4_y[i] = '0; end
            m1_ov = 1'b0; m1_oy = '0; m4_ov = 1'b0; m4_oy = '0;
        end else if (en) begin
            m1_ov = m1_v[16];
            if (m1_v[16]) m1_oy = m1_y[16];
            for (int i = 16; i > 0; i--) begin m1_v[i] = m1_v[i-1]; m1_y[i] = m1_y[i-1]; end
            m1_v[0] = in_valid;
            m1_y[0] = ref_mul(a, b, is_signed);
            m4_ov = m4_v[4];
            if (m4_v[4]) m4_oy = m4_y[4];
            for (int i = 4; i > 0; i--) begin m4_v[i] = m4_v[i-1]; m4_y[i] = m4_y[i-1]; end
            m4_v[0] = in_valid;
            m4_y[0] = ref_mul(a, b, is_signed);
        end
        @(negedge clk);
        check("bps1_out_valid", 32'(ov1), 32'(m1_ov));
        check("bps1_y", y1, m1_oy);
        check("bps4_out_valid", 32'(ov4), 32'(m4_ov));
        check("bps4_y", y4, m4_oy);
    endtask

    task automatic op(input logic [15:0] pa, input logic [15:0] pb, input logic s);
        in_valid = 1'b1; a = pa; b = pb; is_signed = s;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; a = 16'(i * 16'h1357); b = 16'(i * 16'h2468); is_signed = i[0];
            tick();
        end
    endtask

    logic [31:0] exp29 [0:3];

    initial begin
`ifdef MULT_PIPE_SIGNED_EN
        exp29[0] = 32'hFFFFFFFE;
`else
        exp29[0] = 32'h0001FFFE;
`endif
        exp29[1] = 32'h40000000;
        exp29[2] = 32'h40000000;
        exp29[3] = 32'h0001FFFE;

        rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h5678; is_signed = 1'b0;
        @(negedge clk);
        tick();
        check("reset_out_valid", 32'(ov1), 32'h0);
        check("reset_y", y1, 32'h0);
        tick();
        rst = 1'b0;

        // Max unsigned product and exact latency for both configurations.
        op(16'hFFFF, 16'hFFFF, 1'b0);
        for (int k = 2; k <= 18; k++) begin
            idle(1);
            if (k == 5) check("bps4_lat_early", 32'(ov4), 32'h0);
            if (k == 6) begin
                check("bps4_lat6_valid", 32'(ov4), 32'h1);
                check("bps4_ffff_sq", y4, 32'hFFFE0001);
            end
            if (k == 17) check("bps1_lat_early", 32'(ov1), 32'h0);
            if (k == 18) begin
                check("bps1_lat18_valid", 32'(ov1), 32'h1);
                check("bps1_ffff_sq", y1, 32'hFFFE0001);
            end
        end
        idle(2);

        // Mixed signed/unsigned back-to-back, including the most negative operand.
        op(16'hFFFF, 16'h0002, 1'b1);
        op(16'h8000, 16'h8000, 1'b1);
        op(16'h8000, 16'h8000, 1'b0);
        op(16'hFFFF, 16'h0002, 1'b0);
        for (int k = 5; k <= 22; k++) begin
            idle(1);
            if (k >= 6 && k <= 9) check("bps4_mixed", y4, exp29[k-6]);
            if (k >= 18 && k <= 21) check("bps1_mixed", y1, exp29[k-18]);
        end

        // Random back-to-back stream; model covers order, values and throughput.
        for (int i = 0; i < 20; i++) op(16'($urandom), 16'($urandom), 1'($urandom));
        idle(20);

        // Stall mid-flight; in_valid is ignored while en is low.
        op(16'h0003, 16'h0005, 1'b0);
        op(16'hFFFE, 16'h0007, 1'b1);
        op(16'h1234, 16'hABCD, 1'b0);
        idle(2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) op(16'($urandom), 16'($urandom), 1'b0);
        check("stall_frozen_valid", 32'(ov4), 32'h0);
        en = 1'b1;
        idle(1);
        check("stall_resume_valid", 32'(ov4), 32'h1);
        check("stall_resume_y", y4, 32'h0000000F);
        idle(20);

        // Reset discards in-flight work; in_valid on the reset edge is dropped.
        op(16'h0011, 16'h0022, 1'b0);
        op(16'h0033, 16'h0044, 1'b0);
        op(16'h0055, 16'h0066, 1'b0);
        rst = 1'b1;
        op(16'h0077, 16'h0088, 1'b0);
        rst = 1'b0;
        check("post_rst_y", y4, 32'h0);
        op(16'h0100, 16'h0100, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            idle(1);
            if (k < 6) check("post_rst_quiet", 32'(ov4), 32'h0);
            if (k == 6) check("post_rst_first", y4, 32'h00010000);
            if (k < 18) check("post_rst_bps1_y", y1, 32'h0);
        end

        // Reset wins over en=0.
        op(16'h0009, 16'h0009, 1'b0);
        idle(6);
        en = 1'b0; rst = 1'b1;
        idle(1);
        check("rst_en0_valid", 32'(ov4), 32'h0);
        check("rst_en0_y", y4, 32'h0);
        rst = 1'b0; en = 1'b1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
